// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between an instruction-fetch side and a data side.
// Define ARB_ROUND_ROBIN_EN to alternate sides on contention; otherwise the data side always wins.
module mem_port_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic        resp_d_q, resp_d_d;
  logic        err_q, err_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        d_bad, pick_d, pick_if, d_side_wins;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^if_addr[1:0];

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;
  assign d_side_wins = !last_d_q;
`else
  assign d_side_wins = 1'b1;
`endif

  // Illegal byte patterns and accesses not aligned to their own size are rejected.
  always_comb begin
    d_bad = 1'b0;
    case (d_we)
      4'b0000, 4'b0001: d_bad = 1'b0;
      4'b0011:          d_bad = d_addr[0];
      4'b1111:          d_bad = |d_addr[1:0];
      default:          d_bad = 1'b1;
    endcase
  end

  assign pick_d  = d_req && (!if_req || d_side_wins);
  assign pick_if = if_req && !pick_d;

  always_comb begin
    state_d     = state_q;
    resp_d_d    = resp_d_q;
    err_d       = err_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d_d    = last_d_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_if) begin
          if_gnt      = 1'b1;
          state_d     = IF_BUSY;
          resp_d_d    = 1'b0;
          err_d       = 1'b0;
          mem_addr_d  = {if_addr[31:2], 2'b00};
          mem_we_d    = 1'b0;
          mem_be_d    = 4'b1111;
          mem_wdata_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
          last_d_d    = 1'b0;
`endif
        end else if (pick_d) begin
          d_gnt    = 1'b1;
          resp_d_d = 1'b1;
          err_d    = d_bad;
`ifdef ARB_ROUND_ROBIN_EN
          last_d_d = 1'b1;
`endif
          if (d_bad) begin
            state_d = RESP;
          end else begin
            state_d     = D_BUSY;
            mem_addr_d  = {d_addr[31:2], 2'b00};
            mem_we_d    = |d_we;
            mem_be_d    = (d_we == 4'b0000) ? 4'b1111 : (d_we << d_addr[1:0]);
            mem_wdata_d = (d_we == 4'b0000) ? 32'h0 : (d_wdata << {d_addr[1:0], 3'b000});
          end
        end
      end
      IF_BUSY: begin
        if (mem_ack) begin
          if_rdata_d = mem_rdata;
          state_d    = RESP;
        end
      end
      D_BUSY: begin
        if (mem_ack) begin
          d_rdata_d = mem_rdata;
          state_d   = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset drops any in-flight access; a late mem_ack then lands in IDLE and is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      resp_d_q    <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      resp_d_q    <= resp_d_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

  assign mem_req   = (state_q == IF_BUSY) || (state_q == D_BUSY);
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_rvalid = (state_q == RESP) && !resp_d_q;
  assign d_rvalid  = (state_q == RESP) && resp_d_q;
  assign d_err     = (state_q == RESP) && resp_d_q && err_q;

endmodule
